// File: rtl/cc1200spi_regs_pkg.sv
// Shared register map and address-decode helper for the multi-channel
// CC1200 SPI/packet register bank.
package cc1200spi_regs_pkg;

    localparam logic [15:0] CH_STRIDE   = 16'h0040;
    localparam logic [15:0] GLOBAL_BASE = 16'h0400;
    localparam logic [15:0] VERSION_MAJ = 16'h0002;

    localparam logic [5:0] OFF_CTRL    = 6'h00;
    localparam logic [5:0] OFF_STATUS  = 6'h04;
    localparam logic [5:0] OFF_DOUT    = 6'h08;
    localparam logic [5:0] OFF_DIN     = 6'h0C;
    localparam logic [5:0] OFF_WR      = 6'h10;
    localparam logic [5:0] OFF_CLKDIV  = 6'h14;
    localparam logic [5:0] OFF_TXPKT   = 6'h18;
    localparam logic [5:0] OFF_RXPKT   = 6'h1C;
    localparam logic [5:0] OFF_TXWAIT  = 6'h20;
    localparam logic [5:0] OFF_CORTHRE = 6'h24;
    localparam logic [5:0] OFF_RFPOW   = 6'h28;

    localparam logic [15:0] G_IRQ_EN   = GLOBAL_BASE;
    localparam logic [15:0] G_IRQ_STAT = GLOBAL_BASE + 16'h0004;
    localparam logic [15:0] G_VERSION  = GLOBAL_BASE + 16'h0008;

    // Address-only slave error: unaligned, unmapped, missing channel or a
    // write to a read-only location.
    function automatic logic addr_err(input logic [15:0] a, input logic wr,
                                      input int unsigned nch);
        logic [5:0] off;
        logic [9:0] ch;
        off = a[5:0];
        ch  = a[15:6];
        if (a[1:0] != 2'b00)                  return 1'b1;
        if (a == G_IRQ_EN || a == G_IRQ_STAT) return 1'b0;
        if (a == G_VERSION)                   return wr;
        if (32'(ch) >= nch)                   return 1'b1;
        if (off > OFF_RFPOW)                  return 1'b1;
        if (wr && (off == OFF_DIN || off == OFF_RFPOW)) return 1'b1;
        return 1'b0;
    endfunction

endpackage

// File: rtl/cc1200spi_ch_regs.sv
// One channel's register window: config registers, Start pulse generation,
// Busy falling-edge detection and the sticky Done flag.
module cc1200spi_ch_regs
    import cc1200spi_regs_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_we,
    input  logic [5:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic        i_done_clr,
    input  logic        i_busy,
    input  logic [31:0] i_datain,
    input  logic [7:0]  i_rfpow,
    output logic [31:0] o_rdata,
    output logic        o_start,
    output logic        o_trans,
    output logic        o_receive,
    output logic [31:0] o_dataout,
    output logic [3:0]  o_wr,
    output logic [15:0] o_clkdiv,
    output logic [15:0] o_txwait,
    output logic [7:0]  o_txpkt,
    output logic [7:0]  o_rxpkt,
    output logic [7:0]  o_corthre,
    output logic        o_done
);

    logic        r_start, r_trans, r_receive, r_busy_d, r_done;
    logic [31:0] r_dataout;
    logic [3:0]  r_wr;
    logic [15:0] r_clkdiv, r_txwait;
    logic [7:0]  r_txpkt, r_rxpkt, r_corthre;
    logic        w_set, w_clr;

    assign w_set = r_busy_d & ~i_busy;
    assign w_clr = i_done_clr | (i_we & (i_off == OFF_STATUS) & i_wdata[1]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_start   <= 1'b0;
            r_trans   <= 1'b0;
            r_receive <= 1'b0;
            r_busy_d  <= 1'b0;
            r_done    <= 1'b0;
            r_dataout <= '0;
            r_wr      <= '0;
            r_clkdiv  <= '0;
            r_txwait  <= '0;
            r_txpkt   <= '0;
            r_rxpkt   <= '0;
            r_corthre <= '0;
        end else begin
            r_busy_d <= i_busy;
            // A fresh falling edge beats a coincident W1C clear
            r_done   <= w_set | (r_done & ~w_clr);
            r_start  <= i_we & (i_off == OFF_CTRL) & i_wdata[0] & ~i_busy;
            if (i_we) begin
                case (i_off)
                    OFF_CTRL: begin
                        r_trans   <= i_wdata[1];
                        r_receive <= i_wdata[2];
                    end
                    OFF_DOUT:    r_dataout <= i_wdata;
                    OFF_WR:      r_wr      <= i_wdata[3:0];
                    OFF_CLKDIV:  r_clkdiv  <= i_wdata[15:0];
                    OFF_TXPKT:   r_txpkt   <= i_wdata[7:0];
                    OFF_RXPKT:   r_rxpkt   <= i_wdata[7:0];
                    OFF_TXWAIT:  r_txwait  <= i_wdata[15:0];
                    OFF_CORTHRE: r_corthre <= i_wdata[7:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_off)
            OFF_CTRL:    o_rdata = {29'd0, r_receive, r_trans, 1'b0};
            OFF_STATUS:  o_rdata = {30'd0, r_done, i_busy};
            OFF_DOUT:    o_rdata = r_dataout;
            OFF_DIN:     o_rdata = i_datain;
            OFF_WR:      o_rdata = {28'd0, r_wr};
            OFF_CLKDIV:  o_rdata = {16'd0, r_clkdiv};
            OFF_TXPKT:   o_rdata = {24'd0, r_txpkt};
            OFF_RXPKT:   o_rdata = {24'd0, r_rxpkt};
            OFF_TXWAIT:  o_rdata = {16'd0, r_txwait};
            OFF_CORTHRE: o_rdata = {24'd0, r_corthre};
            OFF_RFPOW:   o_rdata = {{24{i_rfpow[7]}}, i_rfpow};
            default:     o_rdata = '0;
        endcase
    end

    assign o_start   = r_start;
    assign o_trans   = r_trans;
    assign o_receive = r_receive;
    assign o_dataout = r_dataout;
    assign o_wr      = r_wr;
    assign o_clkdiv  = r_clkdiv;
    assign o_txwait  = r_txwait;
    assign o_txpkt   = r_txpkt;
    assign o_rxpkt   = r_rxpkt;
    assign o_corthre = r_corthre;
    assign o_done    = r_done;

endmodule

// File: rtl/cc1200spi_regs_mc.sv
// APB3 slave fronting NUM_CH CC1200 channel register windows plus a global
// block (IRQ enable/status, version) and the level interrupt.
module cc1200spi_regs_mc
    import cc1200spi_regs_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [31:0]          APB_S_0_paddr,
    input  logic                 APB_S_0_psel,
    input  logic                 APB_S_0_penable,
    input  logic                 APB_S_0_pwrite,
    input  logic [31:0]          APB_S_0_pwdata,
    output logic [31:0]          APB_S_0_prdata,
    output logic                 APB_S_0_pready,
    output logic                 APB_S_0_pslverr,
    output logic [NUM_CH-1:0]    Start,
    output logic [NUM_CH-1:0]    Trans,
    output logic [NUM_CH-1:0]    Receive,
    input  logic [NUM_CH-1:0]    Busy,
    output logic [32*NUM_CH-1:0] DataOut,
    input  logic [32*NUM_CH-1:0] DataIn,
    output logic [4*NUM_CH-1:0]  WR,
    output logic [16*NUM_CH-1:0] ClockDiv,
    output logic [16*NUM_CH-1:0] Tx_wait,
    output logic [8*NUM_CH-1:0]  Tx_Pkt_size,
    output logic [8*NUM_CH-1:0]  Rx_Pkt_size,
    output logic [8*NUM_CH-1:0]  CorThre,
    input  logic [8*NUM_CH-1:0]  RFpow,
    output logic                 Irq
);

    logic                         r_pready, r_pslverr, r_irq;
    logic [31:0]                  r_prdata;
    logic [NUM_CH-1:0]            r_irq_en;
    logic [15:0]                  w_addr, w_busy16;
    logic [3:0]                   w_ch;
    logic                         w_is_glob, w_aerr, w_busy_serr;
    logic                         w_setup_end, w_complete, w_wr_ok, w_stat_wr;
    logic [31:0]                  w_rdata;
    logic [NUM_CH-1:0]            w_done;
    logic [NUM_CH-1:0][31:0]      w_ch_rdata;
    logic                         w_unused;

    assign w_unused    = ^APB_S_0_paddr[31:ADDR_W];
    assign w_addr      = 16'(APB_S_0_paddr[ADDR_W-1:0]);
    assign w_ch        = w_addr[9:6];
    assign w_is_glob   = (w_addr[15:6] == GLOBAL_BASE[15:6]);
    assign w_busy16    = 16'(Busy);
    assign w_aerr      = addr_err(w_addr, APB_S_0_pwrite, NUM_CH);
    // Start requested on a busy channel: still a legal write, but flagged
    assign w_busy_serr = ~w_aerr & ~w_is_glob & APB_S_0_pwrite &
                         (w_addr[5:0] == OFF_CTRL) & APB_S_0_pwdata[0] & w_busy16[w_ch];

    assign w_setup_end = APB_S_0_psel & APB_S_0_penable & ~r_pready;
    assign w_complete  = APB_S_0_psel & APB_S_0_penable & r_pready;
    assign w_wr_ok     = w_complete & APB_S_0_pwrite & ~w_aerr;
    assign w_stat_wr   = w_wr_ok & (w_addr == G_IRQ_STAT);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cc1200spi_ch_regs u_ch (
            .clk        (clk),
            .rstn       (rstn),
            .i_we       (w_wr_ok & ~w_is_glob & (w_ch == 4'(c))),
            .i_off      (w_addr[5:0]),
            .i_wdata    (APB_S_0_pwdata),
            .i_done_clr (w_stat_wr & APB_S_0_pwdata[c]),
            .i_busy     (Busy[c]),
            .i_datain   (DataIn[32*c +: 32]),
            .i_rfpow    (RFpow[8*c +: 8]),
            .o_rdata    (w_ch_rdata[c]),
            .o_start    (Start[c]),
            .o_trans    (Trans[c]),
            .o_receive  (Receive[c]),
            .o_dataout  (DataOut[32*c +: 32]),
            .o_wr       (WR[4*c +: 4]),
            .o_clkdiv   (ClockDiv[16*c +: 16]),
            .o_txwait   (Tx_wait[16*c +: 16]),
            .o_txpkt    (Tx_Pkt_size[8*c +: 8]),
            .o_rxpkt    (Rx_Pkt_size[8*c +: 8]),
            .o_corthre  (CorThre[8*c +: 8]),
            .o_done     (w_done[c])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (w_is_glob) begin
            case (w_addr)
                G_IRQ_EN:   w_rdata = 32'(r_irq_en);
                G_IRQ_STAT: w_rdata = 32'(w_done);
                G_VERSION:  w_rdata = {VERSION_MAJ, 16'(NUM_CH)};
                default:    w_rdata = '0;
            endcase
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                if (32'(w_ch) == c) w_rdata = w_ch_rdata[c];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_irq_en  <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_pready  <= w_setup_end;
            // Response is captured as pready rises; pslverr self-clears after
            r_pslverr <= w_setup_end & (w_aerr | w_busy_serr);
            if (w_setup_end & ~APB_S_0_pwrite)
                r_prdata <= w_aerr ? 32'd0 : w_rdata;
            if (w_wr_ok & (w_addr == G_IRQ_EN))
                r_irq_en <= APB_S_0_pwdata[NUM_CH-1:0];
            r_irq <= |(w_done & r_irq_en);
        end
    end

    assign APB_S_0_pready  = r_pready;
    assign APB_S_0_pslverr = r_pslverr;
    assign APB_S_0_prdata  = r_prdata;
    assign Irq             = r_irq;

endmodule

// File: tb/tb_cc1200spi_regs_mc.sv
// Directed self-checking bench for cc1200spi_regs_mc with NUM_CH=4.
module tb_cc1200spi_regs_mc;

    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0, prdata;
    logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0, pready, pslverr;
    logic [NCH-1:0] Start, Trans, Receive, Busy = '0;
    logic [32*NCH-1:0] DataOut, DataIn = '0;
    logic [4*NCH-1:0] WR;
    logic [16*NCH-1:0] ClockDiv, Tx_wait;
    logic [8*NCH-1:0] Tx_Pkt_size, Rx_Pkt_size, CorThre, RFpow = '0;
    logic Irq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cc1200spi_regs_mc #(.NUM_CH(NCH), .ADDR_W(12)) dut (
        .clk(clk), .rstn(rstn),
        .APB_S_0_paddr(paddr), .APB_S_0_psel(psel), .APB_S_0_penable(penable),
        .APB_S_0_pwrite(pwrite), .APB_S_0_pwdata(pwdata),
        .APB_S_0_prdata(prdata), .APB_S_0_pready(pready), .APB_S_0_pslverr(pslverr),
        .Start(Start), .Trans(Trans), .Receive(Receive), .Busy(Busy),
        .DataOut(DataOut), .DataIn(DataIn), .WR(WR), .ClockDiv(ClockDiv),
        .Tx_wait(Tx_wait), .Tx_Pkt_size(Tx_Pkt_size), .Rx_Pkt_size(Rx_Pkt_size),
        .CorThre(CorThre), .RFpow(RFpow), .Irq(Irq)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One APB transfer; Busy takes busy_rdy while pready is high so a
    // Busy edge can be placed on the completion edge.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [NCH-1:0] busy_rdy,
                        output logic [31:0] rd, output logic err);
        int lat;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        chk("slverr_idle", 128'(pslverr), 128'(0));
        lat = 0;
        while (!pready && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("pready_lat", 128'(lat), 128'(1));
        rd = prdata;
        err = pslverr;
        Busy = busy_rdy;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;

        RFpow = 32'h0000_F000;
        DataIn = {32'h0, 32'h1122_3344, 32'h0, 32'h0};
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        chk("rst_pready", 128'(pready), 128'(0));
        chk("rst_outs", {Start, Trans, Receive, Irq, WR}, 128'(0));
        chk("rst_dout", DataOut, 128'(0));
        chk("rst_cfg", {ClockDiv, Tx_wait, Tx_Pkt_size, Rx_Pkt_size, CorThre}, 128'(0));

        xfer(1'b0, 32'h408, 32'h0, '0, rd, er);
        chk("version", 128'(rd), 128'(32'h0002_0004));
        chk("version_err", 128'(er), 128'(0));

        // Start pulse on idle channel 1
        xfer(1'b1, 32'h40, 32'h7, '0, rd, er);
        chk("start_err", 128'(er), 128'(0));
        chk("start_pulse", 128'(Start), 128'(4'b0010));
        chk("trans_recv", 128'({Trans, Receive}), 128'({4'b0010, 4'b0010}));
        @(posedge clk); #1;
        chk("start_one_cyc", 128'(Start), 128'(0));

        // Start while busy: error, no pulse, mode bits still written
        Busy = 4'b0010;
        xfer(1'b1, 32'h40, 32'h7, 4'b0010, rd, er);
        chk("busy_start_err", 128'(er), 128'(1));
        chk("busy_no_pulse", 128'(Start), 128'(0));
        xfer(1'b1, 32'h40, 32'h1, 4'b0010, rd, er);
        chk("busy_err2", 128'(er), 128'(1));
        chk("busy_mode_upd", 128'({Trans, Receive}), 128'(0));
        Busy = '0;
        repeat (2) @(posedge clk);
        #1;
        xfer(1'b0, 32'h44, 32'h0, '0, rd, er);
        chk("ch1_done", 128'(rd), 128'(32'h2));
        xfer(1'b1, 32'h44, 32'h2, '0, rd, er);
        xfer(1'b0, 32'h404, 32'h0, '0, rd, er);
        chk("ch1_w1c", 128'(rd), 128'(0));

        // Config register write/readback
        xfer(1'b1, 32'h94, 32'h0000_1234, '0, rd, er);
        chk("clkdiv", ClockDiv, 128'(64'h0000_1234_0000_0000));
        xfer(1'b0, 32'h94, 32'h0, '0, rd, er);
        chk("clkdiv_rd", 128'(rd), 128'(32'h1234));
        xfer(1'b1, 32'h08, 32'hA5A5_0001, '0, rd, er);
        chk("dout0", DataOut, 128'(32'hA5A5_0001));
        xfer(1'b0, 32'h8C, 32'h0, '0, rd, er);
        chk("din2", 128'(rd), 128'(32'h1122_3344));

        // Done / IRQ
        xfer(1'b1, 32'h400, 32'h8, '0, rd, er);
        Busy = 4'b1000;
        repeat (2) @(posedge clk);
        #1 Busy = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("irq_set", 128'(Irq), 128'(1));
        xfer(1'b0, 32'hC4, 32'h0, '0, rd, er);
        chk("ch3_status", 128'(rd), 128'(32'h2));
        xfer(1'b1, 32'h404, 32'h8, '0, rd, er);
        @(posedge clk); #1;
        chk("irq_clr", 128'(Irq), 128'(0));
        xfer(1'b0, 32'h404, 32'h0, '0, rd, er);
        chk("stat_clr", 128'(rd), 128'(0));

        // New falling edge on the clear's completion edge: set wins
        Busy = 4'b1000;
        repeat (2) @(posedge clk);
        #1;
        xfer(1'b1, 32'h404, 32'h8, '0, rd, er);
        xfer(1'b0, 32'h404, 32'h0, '0, rd, er);
        chk("set_wins", 128'(rd), 128'(32'h8));
        chk("irq_set_wins", 128'(Irq), 128'(1));

        // RSSI sign extension and error cases
        xfer(1'b0, 32'h68, 32'h0, '0, rd, er);
        chk("rfpow_sext", 128'(rd), 128'(32'hFFFF_FFF0));
        xfer(1'b1, 32'h0C, 32'hDEAD_BEEF, '0, rd, er);
        chk("err_din", 128'(er), 128'(1));
        xfer(1'b1, 32'h300, 32'hFFFF_FFFF, '0, rd, er);
        chk("err_ch", 128'(er), 128'(1));
        xfer(1'b1, 32'h02, 32'h7, '0, rd, er);
        chk("err_unal", 128'(er), 128'(1));
        chk("err_no_start", 128'(Start), 128'(0));
        chk("err_no_mode", 128'({Trans, Receive}), 128'(0));
        xfer(1'b1, 32'h408, 32'h1, '0, rd, er);
        chk("err_ver", 128'(er), 128'(1));
        chk("err_dout", DataOut, 128'(32'hA5A5_0001));
        chk("err_clkdiv", ClockDiv, 128'(64'h0000_1234_0000_0000));
        xfer(1'b0, 32'h400, 32'h0, '0, rd, er);
        chk("irq_en_kept", 128'(rd), 128'(32'h8));

        // Reset mid-transfer
        @(posedge clk); #1;
        psel = 1'b1; pwrite = 1'b1; paddr = 32'h48; pwdata = 32'h55;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 rstn = 1'b0;
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        chk("mid_rst_pready", 128'(pready), 128'(0));
        chk("mid_rst_dout", DataOut, 128'(0));
        chk("mid_rst_irq", 128'({Irq, ClockDiv}), 128'(0));
        @(posedge clk); #1 rstn = 1'b1;
        xfer(1'b0, 32'h404, 32'h0, '0, rd, er);
        chk("mid_rst_done", 128'(rd), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cc1200spi_regs_mc.md
# cc1200spi_regs_mc

Multi-channel APB register bank for the CC1200 SPI/packet subsystem, replacing the single-channel register file so one APB slave controls NUM_CH independent CC1200 transceivers. Each channel gets its own register window with start/mode, SPI data, clock-divider and packet-engine configuration. Completion of each channel's transaction is latched as a sticky, write-1-to-clear status bit feeding a maskable interrupt. The APB side gains a clean one-wait-state handshake, single-shot write side effects and real slave-error reporting.

## Interface
- NUM_CH, 4, number of CC1200 channels (1..16)
- ADDR_W, 12, decoded APB address bits (paddr[ADDR_W-1:0]); upper bits ignored
- clk  in  1  system clock; all inputs synchronous to it
- rstn  in  1  reset, asynchronous, active-low
- APB_S_0_paddr / psel / penable / pwrite / pwdata  in  32/1/1/1/32  APB3 request
- APB_S_0_prdata / pready / pslverr  out  32/1/1  APB3 response
- Start  out  NUM_CH  per-channel one-cycle start pulse
- Trans, Receive  out  NUM_CH each  per-channel mode bits
- Busy  in  NUM_CH  per-channel engine busy
- DataOut / DataIn  out/in  32*NUM_CH  SPI write / read data, channel c at [32c+31:32c]
- WR  out  4*NUM_CH  per-channel write-byte mask
- ClockDiv, Tx_wait  out  16*NUM_CH each
- Tx_Pkt_size, Rx_Pkt_size, CorThre  out  8*NUM_CH each
- RFpow  in  8*NUM_CH  signed RSSI per channel
- Irq  out  1  level interrupt

## Operation
- Channel c window at c*0x40. Offsets: 0x00 CTRL (b0 Start wo, b1 Trans, b2 Receive); 0x04 STATUS ro/W1C (b0 Busy ro, b1 Done W1C); 0x08 DataOut; 0x0C DataIn ro; 0x10 WR[3:0]; 0x14 ClockDiv[15:0]; 0x18 Tx_Pkt_size; 0x1C Rx_Pkt_size; 0x20 Tx_wait[15:0]; 0x24 CorThre; 0x28 RFpow ro, sign-extended to 32.
- Global at 0x400: IRQ_EN[NUM_CH-1:0] rw; 0x404 IRQ_STAT = Done vector, W1C; 0x408 VERSION ro = {16'h0002, NUM_CH[15:0]}.
- Reads return zeros in unused bits; CTRL b0 reads 0.
- Start: completed CTRL write with b0=1 pulses Start[c] for exactly one cycle; if Busy[c]=1 at completion, no pulse, pslverr=1, Trans/Receive still updated.
- Done[c] set on Busy[c] falling edge (registered Busy_d & ~Busy). Same-cycle set and W1C clear: set wins.
- Irq = |(Done & IRQ_EN), registered.
- pslverr=1 (no side effect) for: unmapped offset, channel index >= NUM_CH, write to DataIn/RFpow/VERSION, unaligned paddr[1:0]!=0.

## Timing
- Every transfer takes exactly one wait state: pready_q <= psel & penable & ~pready_q; transfer completes in cycle with psel & penable & pready.
- All write side effects and W1C clears occur only at the completion edge, exactly once per transfer.
- prdata and pslverr registered at the edge pready rises; prdata held until next read capture; pslverr=0 whenever pready=0.
- Start pulse high in the cycle after completion edge; Done visible on read one cycle after Busy falls; Irq one cycle after Done.
- Reset (any time, including mid-transfer): all outputs 0, Done and IRQ_EN cleared, Busy_d=0; a transfer interrupted by reset is discarded and must be reissued.

## Structure
- Package cc1200spi_regs_pkg: register offsets, CH_STRIDE=0x40, GLOBAL_BASE=0x400, VERSION constant, error-decode helper.
- Sub-module cc1200spi_ch_regs: one channel's registers, Start pulse, Busy edge detect, Done; generated NUM_CH times. Top holds APB handshake, channel decode, read mux, IRQ_EN, Irq.

## Test plan
- Reset then read 0x408 -> prdata=0x00020004, pslverr=0; all outputs 0, pready rises exactly one cycle after penable.
- Write 0x7 to 0x40 (ch1 CTRL), Busy=0 -> Start=4'b0010 for one cycle, Trans[1]=Receive[1]=1; repeat with Busy[1]=1 -> no pulse, pslverr=1.
- Write 0x00001234 to 0x94 (ch2 ClockDiv) -> ClockDiv[47:32]=0x1234, others unchanged; read back 0x1234.
- Busy[3] 1->0 with IRQ_EN=0x8 -> STATUS ch3 reads 0x2, Irq=1; write 0x8 to 0x404 -> Irq=0; coincident new falling edge in clear cycle -> Done stays 1.
- RFpow[15:8]=8'hF0 read 0x68 -> 0xFFFFFFF0; write to 0x0C, 0x300 (NUM_CH=4), 0x02 -> pslverr=1, no state change.
